// File: rtl/simple_log_udp_noc_read_ctrl.sv
// Control FSM for the log read path: takes a 3-flit request, reads the log, returns 3 flits.
// Optional build macro LOG_RD_TIMEOUT_EN bounds the wait for log read data.
package simple_log_udp_noc_read_ctrl_pkg;
    typedef enum logic [1:0] {
        HDR  = 2'd0,
        META = 2'd1,
        DATA = 2'd2
    } simple_log_resp_sel_e;
endpackage

module simple_log_udp_noc_read_ctrl
    import simple_log_udp_noc_read_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 ctovr_reader_in_val,
    output logic                 ctovr_reader_in_rdy,

    output logic                 reader_out_vrtoc_val,
    input  logic                 reader_out_vrtoc_rdy,

    output logic                 log_rd_req_val,
    input  logic                 log_rd_req_rdy,

    input  logic                 log_rd_resp_val,
    output logic                 log_rd_resp_rdy,

    output logic                 ctrl_datap_store_hdr,
    output logic                 ctrl_datap_store_meta,
    output logic                 ctrl_datap_store_req,
    output logic                 ctrl_datap_store_log_resp,
    output simple_log_resp_sel_e ctrl_datap_output_flit_sel,

    input  logic                 datap_ctrl_rd_meta
);

    typedef enum logic [2:0] {
        RX_HDR,
        RX_META,
        RX_REQ,
        RD_REQ,
        RD_RESP,
        TX_HDR,
        TX_META,
        TX_DATA
    } state_e;

    state_e state;
    state_e state_nxt;
    logic   in_hs;
    logic   resp_hs;
    logic   timeout_hit;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign in_hs   = ctovr_reader_in_val & ctovr_reader_in_rdy;
    assign resp_hs = log_rd_resp_val & log_rd_resp_rdy;

    // Strobes follow the live handshake so the datapath captures in the same cycle.
    assign ctrl_datap_store_hdr      = in_hs & (state == RX_HDR);
    assign ctrl_datap_store_meta     = in_hs & (state == RX_META);
    assign ctrl_datap_store_req      = in_hs & (state == RX_REQ);
    assign ctrl_datap_store_log_resp = (~rst & (state == RD_REQ) & datap_ctrl_rd_meta) | resp_hs;
    assign log_rd_req_val            = ~rst & (state == RD_REQ) & ~datap_ctrl_rd_meta;

`ifdef LOG_RD_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] to_cnt;

    assign timeout_hit = (state == RD_RESP) && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Zero outside RD_RESP, so every entry starts counting from a clean value.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if ((state == RD_RESP) && (state_nxt == RD_RESP)) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            RX_HDR:  if (in_hs) state_nxt = RX_META;
            RX_META: if (in_hs) state_nxt = RX_REQ;
            RX_REQ:  if (in_hs) state_nxt = RD_REQ;
            RD_REQ: begin
                if (datap_ctrl_rd_meta) begin
                    state_nxt = TX_HDR;
                end else if (log_rd_req_rdy) begin
                    state_nxt = RD_RESP;
                end
            end
            RD_RESP: begin
                if (log_rd_resp_val) begin
                    state_nxt = TX_HDR;
                end else if (timeout_hit) begin
                    state_nxt = RX_HDR;
                end
            end
            TX_HDR:  if (reader_out_vrtoc_rdy) state_nxt = TX_META;
            TX_META: if (reader_out_vrtoc_rdy) state_nxt = TX_DATA;
            TX_DATA: if (reader_out_vrtoc_rdy) state_nxt = RX_HDR;
            default: state_nxt = RX_HDR;
        endcase
    end

    // State-only handshake outputs are decoded from the next state so they come straight off flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                      <= RX_HDR;
            ctovr_reader_in_rdy        <= 1'b0;
            reader_out_vrtoc_val       <= 1'b0;
            log_rd_resp_rdy            <= 1'b0;
            ctrl_datap_output_flit_sel <= HDR;
        end else begin
            state                <= state_nxt;
            ctovr_reader_in_rdy  <= state_nxt inside {RX_HDR, RX_META, RX_REQ};
            reader_out_vrtoc_val <= state_nxt inside {TX_HDR, TX_META, TX_DATA};
            log_rd_resp_rdy      <= (state_nxt == RD_RESP);
            case (state_nxt)
                TX_META: ctrl_datap_output_flit_sel <= META;
                TX_DATA: ctrl_datap_output_flit_sel <= DATA;
                default: ctrl_datap_output_flit_sel <= HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_simple_log_udp_noc_read_ctrl.sv
// Scoreboard bench for simple_log_udp_noc_read_ctrl: per-request event sequences vs. observed strobes/handshakes.
module tb_simple_log_udp_noc_read_ctrl;
    localparam int TO_CYC = 16;

    // Event codes seen by the monitor, in protocol order.
    localparam int EV_HDR = 0, EV_META = 1, EV_REQ = 2, EV_RDREQ = 3, EV_LOGRESP = 4;
    localparam int EV_OHDR = 5, EV_OMETA = 6, EV_ODATA = 7;

    logic clk, rst;
    logic in_val, in_rdy, out_val, out_rdy;
    logic req_val, req_rdy, resp_val, resp_rdy;
    logic st_hdr, st_meta, st_req, st_resp, rd_meta;
    simple_log_udp_noc_read_ctrl_pkg::simple_log_resp_sel_e sel;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_q[$];
    int ev_cyc[8];
    bit rand_mode = 0;
    int rr_wait = 0;

    simple_log_udp_noc_read_ctrl #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .ctovr_reader_in_val        (in_val),
        .ctovr_reader_in_rdy        (in_rdy),
        .reader_out_vrtoc_val       (out_val),
        .reader_out_vrtoc_rdy       (out_rdy),
        .log_rd_req_val             (req_val),
        .log_rd_req_rdy             (req_rdy),
        .log_rd_resp_val            (resp_val),
        .log_rd_resp_rdy            (resp_rdy),
        .ctrl_datap_store_hdr       (st_hdr),
        .ctrl_datap_store_meta      (st_meta),
        .ctrl_datap_store_req       (st_req),
        .ctrl_datap_store_log_resp  (st_resp),
        .ctrl_datap_output_flit_sel (sel),
        .datap_ctrl_rd_meta         (rd_meta)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d errors so far", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples mid-cycle, turns strobes/handshakes into events and pops the scoreboard.
    initial begin
        bit prev_out_stall = 0, prev_req_stall = 0;
        int prev_sel = 0;
        forever begin
            int n, code;
            @(negedge clk);
            cyc++;
            if (!rst) begin
                n = 0;
                code = -1;
                if (st_hdr)            begin n++; code = EV_HDR;     end
                if (st_meta)           begin n++; code = EV_META;    end
                if (st_req)            begin n++; code = EV_REQ;     end
                if (req_val & req_rdy) begin n++; code = EV_RDREQ;   end
                if (st_resp)           begin n++; code = EV_LOGRESP; end
                if (out_val & out_rdy) begin n++; code = EV_OHDR + int'(sel); end
                chk("events_per_cycle_le1", (n <= 1) ? 1 : 0, 1);
                if (n == 1) begin
                    ev_cyc[code < 8 && code >= 0 ? code : 0] = cyc;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_event", code, -1);
                    end else begin
                        chk("event_order", code, exp_q.pop_front());
                    end
                end
                if (!out_val) chk("idle_sel_is_hdr", int'(sel), 0);
                chk("in_rdy_out_val_exclusive", int'(in_rdy & out_val), 0);
                if (prev_out_stall) begin
                    chk("out_val_held", int'(out_val), 1);
                    chk("out_sel_held", int'(sel), prev_sel);
                end
                if (prev_req_stall) chk("req_val_held", int'(req_val), 1);
            end
            prev_out_stall = !rst && out_val && !out_rdy;
            prev_req_stall = !rst && req_val && !req_rdy;
            prev_sel = int'(sel);
        end
    end

    // One clock step; inputs change 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            rr_wait = resp_rdy ? rr_wait + 1 : 0;
            out_rdy  = 1'($urandom % 2);
            req_rdy  = 1'($urandom % 2);
            resp_val = (rr_wait >= 8) ? 1'b1 : 1'($urandom % 2);
        end
    endtask

    task automatic push_txn(input bit meta, input bit timed_out);
        exp_q.push_back(EV_HDR);
        exp_q.push_back(EV_META);
        exp_q.push_back(EV_REQ);
        if (!meta) exp_q.push_back(EV_RDREQ);
        if (!timed_out) begin
            exp_q.push_back(EV_LOGRESP);
            exp_q.push_back(EV_OHDR);
            exp_q.push_back(EV_OMETA);
            exp_q.push_back(EV_ODATA);
        end
    endtask

    task automatic send_flits(input bit meta, input int gap_max);
        rd_meta = meta;
        for (int f = 0; f < 3; f++) begin
            int n;
            repeat ($urandom_range(gap_max, 0)) tick();
            in_val = 1'b1;
            n = 0;
            while (!in_rdy && n < 300) begin
                tick();
                n++;
            end
            if (n >= 300) chk("in_rdy_timeout", 0, 1);
            tick();
            in_val = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) begin
            chk("txn_completion_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic send_txn(input bit meta, input int gap_max);
        push_txn(meta, 1'b0);
        send_flits(meta, gap_max);
        wait_done();
    endtask

    initial begin
        int lat_e[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
        int lat_m[8] = '{0, 1, 2, -1, 3, 4, 5, 6};
        int n;

        // Reset with every input pulling for activity.
        rst = 1'b1; in_val = 1'b1; out_rdy = 1'b1; req_rdy = 1'b1; resp_val = 1'b1; rd_meta = 1'b1;
        repeat (3) tick();
        chk("rst_in_rdy", int'(in_rdy), 0);
        chk("rst_out_val", int'(out_val), 0);
        chk("rst_req_val", int'(req_val), 0);
        chk("rst_resp_rdy", int'(resp_rdy), 0);
        chk("rst_strobes", int'({st_hdr, st_meta, st_req, st_resp}), 0);
        chk("rst_sel", int'(sel), 0);
        in_val = 1'b0; resp_val = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        chk("post_rst_in_rdy", int'(in_rdy), 1);

        // Entry read, everything immediate: fixed cycle offsets from store_hdr.
        out_rdy = 1'b1; req_rdy = 1'b1; resp_val = 1'b1;
        send_txn(1'b0, 0);
        for (int k = 0; k < 8; k++) chk($sformatf("entry_latency_ev%0d", k), ev_cyc[k] - ev_cyc[0], lat_e[k]);

        // Metadata read: no log request, one log_resp strobe, three flits.
        send_txn(1'b1, 0);
        for (int k = 0; k < 8; k++)
            if (k != EV_RDREQ) chk($sformatf("meta_latency_ev%0d", k), ev_cyc[k] - ev_cyc[0], lat_m[k]);

        // Stall: request accepted after 4 cycles, data after 3 more.
        req_rdy = 1'b0; resp_val = 1'b0;
        push_txn(1'b0, 1'b0);
        send_flits(1'b0, 0);
        n = 0;
        while (!req_val && n < 20) begin tick(); n++; end
        for (int k = 0; k < 4; k++) begin
            chk("stall_req_val", int'(req_val), 1);
            if (k == 3) req_rdy = 1'b1;
            tick();
        end
        req_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stall_resp_rdy", int'(resp_rdy), 1);
            tick();
        end
        resp_val = 1'b1;
        chk("stall_resp_rdy_on_data", int'(resp_rdy), 1);
        tick();
        resp_val = 1'b0;
        wait_done();

        // Backpressure in TX_META for 5 cycles, then reset mid-transaction.
        push_txn(1'b1, 1'b0);
        send_flits(1'b1, 0);
        n = 0;
        while (!(out_val && int'(sel) == 1) && n < 20) begin tick(); n++; end
        out_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_val", int'(out_val), 1);
            chk("bp_sel_meta", int'(sel), 1);
            tick();
        end
        rst = 1'b1;
        exp_q.delete();
        tick();
        chk("mid_rst_out_val", int'(out_val), 0);
        chk("mid_rst_sel", int'(sel), 0);
        rst = 1'b0;
        out_rdy = 1'b1; req_rdy = 1'b1; resp_val = 1'b1;
        tick();
        chk("mid_rst_idle_in_rdy", int'(in_rdy), 1);
        send_txn(1'b0, 1);

`ifdef LOG_RD_TIMEOUT_EN
        // No log data: back to idle after TO_CYC cycles with no output, then serve again.
        resp_val = 1'b0;
        push_txn(1'b0, 1'b1);
        send_flits(1'b0, 0);
        wait_done();
        n = 0;
        while (!in_rdy && n < 100) begin tick(); n++; end
        chk("timeout_cycles", n, TO_CYC);
        resp_val = 1'b1;
        send_txn(1'b1, 0);
        send_txn(1'b0, 0);
`endif

        // Randomized traffic.
        rand_mode = 1'b1;
        for (int t = 0; t < 40; t++) send_txn(1'($urandom % 2), 2);
        rand_mode = 1'b0;
        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
